instr_fetch_issue: RTL

Instruction fetch and issue unit. It is the producer side of the 32-bit instruction word the ALU consumes, with opcode in code[31:26]. It fetches from a synchronous instruction ROM, buffers up to two words, handles JMP and HALT internally, and presents every other word to the ALU over a valid/ready handshake.

---
 rtl/instr_fetch_issue.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_issue.sv
// Instruction fetch and issue unit.
// Fetches from a 1-cycle synchronous ROM into a 2-entry FIFO, consumes JMP
// and HALT internally and offers every other word to the ALU over valid/ready.
module instr_fetch_issue #(
  parameter int unsigned PC_W    = 8,
  parameter logic [5:0]  OP_JMP  = 6'b010001,
  parameter logic [5:0]  OP_HALT = 6'b111111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  output logic            imem_rd_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [31:0]     code,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     issue_count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OCC_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                start_take;

  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     pc_d;
  logic                rd_en_q;
  logic                rd_en_d;
  logic                infl_q;
  logic                stale_q;
  logic                stale_d;

  logic [WORD_W-1:0]   ent_q [2];
  logic [WORD_W-1:0]   ent_d [2];
  logic [1:0]          cnt_q;
  logic [1:0]          cnt_d;
  logic                wr_idx;
  logic [OCC_W-1:0]    occ_d;

  logic                valid_q;
  logic                valid_d;
  logic [WORD_W-1:0]   code_q;
  logic [WORD_W-1:0]   code_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                busy_q;
  logic                busy_d;
  logic                halted_q;
  logic                halted_d;

  logic                run;
  logic [5:0]          head_op;
  logic                head_jmp;
  logic                head_halt;
  logic                flush;
  logic                xfer;
  logic                push;

  function automatic logic is_ctrl(input logic [5:0] op);
    return (op == OP_JMP) || (op == OP_HALT);
  endfunction

  // Head decode and per-cycle FIFO events.
  always_comb begin
    run       = (state_q == S_RUN);
    head_op   = ent_q[0][31:26];
    head_jmp  = run && (cnt_q != 2'd0) && (head_op == OP_JMP);
    head_halt = run && (cnt_q != 2'd0) && (head_op == OP_HALT);
    flush     = head_jmp || head_halt;
    xfer      = valid_q && issue_ready;
    // Returning data is dropped if stale, outside RUN, or beaten by a flush.
    push      = run && infl_q && !stale_q && !flush;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is honoured only outside RUN.
  always_comb begin
    state_d    = state_q;
    start_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          start_take = 1'b1;
        end
      end
      S_RUN: begin
        if (head_halt) begin
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d    = S_RUN;
          start_take = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values of the FIFO, pc, fetch strobe and registered outputs.
  always_comb begin
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    wr_idx  = 1'b0;
    occ_d   = '0;
    rd_en_d = 1'b0;
    stale_d = 1'b0;
    valid_d = 1'b0;
    code_d  = code_q;
    count_d = count_q + CNT_W'(xfer);
    busy_d  = (state_d == S_RUN);
    halted_d = (state_d == S_HALTED);

    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      if (xfer) begin
        ent_d[0] = ent_q[1];
      end
      // Slot the returning word lands in after any same-cycle pop.
      wr_idx = xfer ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
      if (push) begin
        ent_d[wr_idx] = imem_data;
      end
      cnt_d = cnt_q - 2'(xfer) + 2'(push);
    end

    if (start_take) begin
      pc_d = start_addr;
    end else if (head_jmp) begin
      pc_d = ent_q[0][PC_W-1:0];
    end else if (rd_en_q) begin
      pc_d = pc_q + PC_W'(1);
    end

    // A read issued during a flush cycle returns after the flush and must be dropped.
    stale_d = flush;

    // The read issued this cycle is the in-flight read of the next cycle.
    occ_d   = OCC_W'(cnt_d) + OCC_W'(rd_en_q);
    rd_en_d = (state_d == S_RUN) && (occ_d < OCC_W'(2));

    valid_d = (state_d == S_RUN) && (cnt_d != 2'd0) && !is_ctrl(ent_d[0][31:26]);
    if (valid_d) begin
      code_d = ent_d[0];
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      rd_en_q  <= 1'b0;
      infl_q   <= 1'b0;
      stale_q  <= 1'b0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      cnt_q    <= 2'd0;
      valid_q  <= 1'b0;
      code_q   <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rd_en_q  <= rd_en_d;
      infl_q   <= rd_en_q;
      stale_q  <= stale_d;
      ent_q    <= ent_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign imem_rd_en  = rd_en_q;
  assign imem_addr   = pc_q;
  assign issue_valid = valid_q;
  assign code        = code_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign issue_count = count_q;

endmodule
